multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu_if.sv | 28 ++
 rtl/multicycle_alu.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu_if.sv
// Request/result bundle for multicycle_alu. The master issues operations and the
// slave (the ALU) returns status, the result and the flags.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [2:0]       i_op;
  logic             i_dir;
  logic             i_cin;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_res;
  logic             o_carry_f;
  logic             o_zero_f;
  logic             o_neg_f;

  modport master (
    output i_start, i_op, i_dir, i_cin, i_a, i_b,
    input  o_busy, o_done, o_res, o_carry_f, o_zero_f, o_neg_f
  );

  modport slave (
    input  i_start, i_op, i_dir, i_cin, i_a, i_b,
    output o_busy, o_done, o_res, o_carry_f, o_zero_f, o_neg_f
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle ALU. Single-cycle ops finish through DONE, shifts step one bit per
// cycle and MUL runs a WIDTH-cycle shift-add. The result and flags are registered.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  multicycle_alu_if.slave bus
);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_COMP = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHA  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic             r_dir;
  logic             r_cin;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [SHW:0]     r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_done;
  logic             r_carry;
  logic             r_zero;
  logic             r_neg;

  logic             w_busy;
  logic [SHW-1:0]   w_amt;
  logic             w_is_shift;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_result;
  logic             w_carry_new;

  assign w_amt      = bus.i_b[SHW-1:0];
  assign w_is_shift = (bus.i_op == OP_SHL) || (bus.i_op == OP_SHA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A zero shift amount has nothing to iterate, so it goes straight to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          if (bus.i_op == OP_MUL) begin
            w_next = MUL;
          end else if (w_is_shift && (w_amt != '0)) begin
            w_next = SHIFT;
          end else begin
            w_next = DONE;
          end
        end
      end
      SHIFT:   if (r_cnt == CNT_ONE) w_next = DONE;
      MUL:     if (r_cnt == CNT_ONE) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  // Multiplier bits shift out of r_b's LSB while product bits shift in at its MSB.
  always_comb begin
    w_sum     = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
    w_mul_sum = {1'b0, r_hi} + (r_b[0] ? {1'b0, r_a} : '0);
    case (r_op)
      OP_SHL:  w_shifted = r_dir ? {1'b0, r_a[WIDTH-1:1]} : {r_a[WIDTH-2:0], 1'b0};
      OP_SHA:  w_shifted = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
      default: w_shifted = r_a;
    endcase
  end

  always_comb begin
    w_result    = r_a;
    w_carry_new = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_result    = w_sum[WIDTH-1:0];
        w_carry_new = w_sum[WIDTH];
      end
      OP_COMP: w_result = ~r_b + 1'b1;
      OP_AND:  w_result = r_a & r_b;
      OP_XOR:  w_result = r_a ^ r_b;
      OP_SHL:  w_result = r_a;
      OP_SHA:  w_result = r_a;
      OP_MUL: begin
        w_result    = r_b;
        w_carry_new = |r_hi;
      end
      OP_PASS: w_result = r_a;
      default: w_result = r_a;
    endcase
  end

  // Operands are captured only at acceptance, so later input activity cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_dir   <= 1'b0;
      r_cin   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_done  <= 1'b0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_op  <= bus.i_op;
            r_dir <= bus.i_dir;
            r_cin <= bus.i_cin;
            r_a   <= bus.i_a;
            r_b   <= bus.i_b;
            r_hi  <= '0;
            r_cnt <= (bus.i_op == OP_MUL) ? CNT_MUL : {1'b0, w_amt};
          end
        end
        SHIFT: begin
          r_a   <= w_shifted;
          r_cnt <= r_cnt - CNT_ONE;
        end
        MUL: begin
          r_hi  <= w_mul_sum[WIDTH:1];
          r_b   <= {w_mul_sum[0], r_b[WIDTH-1:1]};
          r_cnt <= r_cnt - CNT_ONE;
        end
        DONE: begin
          r_res  <= w_result;
          r_zero <= (w_result == '0);
          r_neg  <= w_result[WIDTH-1];
          if ((r_op == OP_ADD) || (r_op == OP_MUL)) begin
            r_carry <= w_carry_new;
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy    = w_busy;
  assign bus.o_done    = r_done;
  assign bus.o_res     = r_res;
  assign bus.o_carry_f = r_carry;
  assign bus.o_zero_f  = r_zero;
  assign bus.o_neg_f   = r_neg;
endmodule
